// File: rtl/alaw_pcm_tx.sv
// alaw_pcm_tx: serial PCM transmitter for 8-bit A-law codes.
// Codes arrive over a valid/ready handshake and wait in a small FIFO. Each code
// is optionally XORed with 8'h55 (A-law even-bit inversion) and shifted out MSB
// first as an 8-bit frame with frame sync and bit clock. An empty FIFO at a
// frame boundary while enabled sends an idle code and bumps a saturating count.
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_code         A-law code from the compander
//   i_code_valid   i_code valid this cycle
//   o_code_ready   FIFO not full (0 while in reset)
//   i_en           transmit enable
//   o_pcm_data     serial data, MSB first
//   o_pcm_fsync    high during the first bit period of each frame
//   o_pcm_bclk     high during the first half of each bit period
//   o_fifo_level   FIFO occupancy
//   o_underrun_cnt idle frames sent, saturating at 255
module alaw_pcm_tx #(
    parameter int DEPTH       = 4,
    parameter int BIT_DIV     = 4,
    parameter bit INVERT_EVEN = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_code,
    input  logic                     i_code_valid,
    output logic                     o_code_ready,
    input  logic                     i_en,
    output logic                     o_pcm_data,
    output logic                     o_pcm_fsync,
    output logic                     o_pcm_bclk,
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic [7:0]               o_underrun_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(BIT_DIV);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BIT_DIV / 2);
    localparam logic [7:0]    MASK     = INVERT_EVEN ? 8'h55 : 8'h00;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state, w_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd, r_wr;
    logic [AW:0]   r_level;
    logic [DW-1:0] r_div, w_div;
    logic [2:0]    r_bit, w_bit;
    logic [7:0]    r_shift, w_shift;
    logic [7:0]    r_under;
    logic          r_data, r_fsync, r_bclk;
    logic          w_push, w_pop, w_last, w_under;

    // Ready comes from the registered level, so a pop in the same cycle
    // cannot open a slot for a push while full.
    assign o_code_ready   = i_rst_n && (r_level != FULL);
    assign w_push         = i_code_valid && o_code_ready;
    assign w_last         = (r_bit == 3'd7) && (r_div == DIV_LAST);
    assign o_pcm_data     = r_data;
    assign o_pcm_fsync    = r_fsync;
    assign o_pcm_bclk     = r_bclk;
    assign o_fifo_level   = r_level;
    assign o_underrun_cnt = r_under;

    always_comb begin
        w_state = r_state;
        w_div   = r_div;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_pop   = 1'b0;
        w_under = 1'b0;
        if (r_state == IDLE) begin
            if (i_en && r_level != '0) begin
                w_state = RUN;
                w_pop   = 1'b1;
                w_shift = r_mem[r_rd] ^ MASK;
            end
        end else if (w_last) begin
            w_div = '0;
            w_bit = '0;
            if (!i_en) begin
                w_state = IDLE;
                w_shift = '0;
            end else if (r_level != '0) begin
                w_pop   = 1'b1;
                w_shift = r_mem[r_rd] ^ MASK;
            end else begin
                w_under = 1'b1;
                w_shift = MASK;
            end
        end else if (r_div == DIV_LAST) begin
            w_div   = '0;
            w_bit   = r_bit + 3'd1;
            w_shift = {r_shift[6:0], 1'b0};
        end else begin
            w_div = r_div + DW'(1);
        end
    end

    // Line outputs are registered from next-state values so the first bit of
    // a frame appears in the cycle right after the loading edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
            r_under <= '0;
            r_data  <= 1'b0;
            r_fsync <= 1'b0;
            r_bclk  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            if (w_under && r_under != 8'hFF) r_under <= r_under + 8'd1;
            r_data  <= (w_state == RUN) && w_shift[7];
            r_fsync <= (w_state == RUN) && (w_bit == 3'd0);
            r_bclk  <= (w_state == RUN) && (w_div < DIV_HALF);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_code;
    end
endmodule

// File: tb/tb_alaw_pcm_tx.sv
// tb_alaw_pcm_tx: self-checking bench for alaw_pcm_tx against a frame-time model.
module tb_alaw_pcm_tx;
    localparam int DEPTH   = 4;
    localparam int BIT_DIV = 4;
    localparam int FL      = 8 * BIT_DIV;
    localparam logic [7:0] MASK = 8'h55;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       en = 1'b0;
    logic [7:0] code = 8'h00;
    logic       ready, data, fsync, bclk;
    logic [2:0] level;
    logic [7:0] under;

    alaw_pcm_tx #(.DEPTH(DEPTH), .BIT_DIV(BIT_DIV), .INVERT_EVEN(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_code(code), .i_code_valid(valid),
        .o_code_ready(ready), .i_en(en), .o_pcm_data(data), .o_pcm_fsync(fsync),
        .o_pcm_bclk(bclk), .o_fifo_level(level), .o_underrun_cnt(under)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int burst = 0;
    logic [7:0] step = 8'h01;

    // Model: queue of waiting codes plus position t (cycles) inside the current frame.
    logic [7:0] q[$];
    bit         m_run;
    int         t;
    logic [7:0] cur;
    int         m_und;

    typedef struct {logic [7:0] code; logic [7:0] line;} vec_t;
    vec_t tbl[5];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_run = 0;
        t = 0;
        cur = 8'h00;
        m_und = 0;
    endtask

    task automatic model_edge();
        bit push = valid && q.size() < DEPTH;
        logic [7:0] pc = code;
        if (!m_run) begin
            if (en && q.size() > 0) begin
                m_run = 1;
                t = 0;
                cur = q.pop_front() ^ MASK;
            end
        end else if (t == FL - 1) begin
            t = 0;
            if (!en) m_run = 0;
            else if (q.size() > 0) cur = q.pop_front() ^ MASK;
            else begin
                cur = MASK;
                if (m_und < 255) m_und++;
            end
        end else t++;
        if (push) q.push_back(pc);
    endtask

    function automatic logic [14:0] model_out();
        logic d, f, b;
        d = m_run ? cur[7 - t / BIT_DIV] : 1'b0;
        f = m_run && t < BIT_DIV;
        b = m_run && (t % BIT_DIV) < BIT_DIV / 2;
        return {rst_n && q.size() != DEPTH, d, f, b, 3'(q.size()), 8'(m_und)};
    endfunction

    task automatic cycle();
        bit pushed;
        @(posedge clk);
        pushed = rst_n && valid && q.size() < DEPTH;
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        cyc++;
        check("cycle", {17'd0, ready, data, fsync, bclk, level, under}, {17'd0, model_out()});
        if (pushed && burst > 0) begin
            burst--;
            if (burst == 0) valid = 1'b0;
            else code = code + step;
        end
    endtask

    task automatic capture(output logic [7:0] got, output int start);
        int w = 0;
        while (fsync !== 1'b1 && w < 4 * FL) begin
            cycle();
            w++;
        end
        check("fsync_seen", {31'd0, fsync}, 32'd1);
        start = cyc;
        got = 8'h00;
        for (int b = 0; b < 8; b++) begin
            got[7-b] = data;
            repeat (BIT_DIV) cycle();
        end
    endtask

    task automatic push_burst(logic [7:0] first, logic [7:0] inc, int n);
        code = first;
        step = inc;
        burst = n;
        valid = 1'b1;
    endtask

    initial begin
        logic [7:0] got;
        int s0, s1, s2, s3, fs;
        tbl[0] = '{8'hA3, 8'hF6};
        tbl[1] = '{8'h00, 8'h55};
        tbl[2] = '{8'hFF, 8'hAA};
        tbl[3] = '{8'h5A, 8'h0F};
        tbl[4] = '{8'h81, 8'hD4};
        model_reset();
        #1;
        check("reset_vals", {17'd0, ready, data, fsync, bclk, level, under}, 32'd0);
        repeat (2) cycle();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Single codes: EN dropped once the frame is running; frame must still finish.
        for (int i = 0; i < 5; i++) begin
            en = 1'b1;
            push_burst(tbl[i].code, 8'h00, 1);
            cycle();
            check("level_after_push", {29'd0, level}, 32'd1);
            cycle();
            check("first_fsync", {31'd0, fsync}, 32'd1);
            en = 1'b0;
            capture(got, s0);
            check("single_line", {24'd0, got}, {24'd0, tbl[i].line});
            check("idle_after", {29'd0, fsync, bclk, data}, 32'd0);
        end

        // Back-to-back codes, then an underrun frame.
        en = 1'b1;
        push_burst(8'h12, 8'h22, 3);
        capture(got, s0);
        check("b2b_0", {24'd0, got}, 32'h47);
        capture(got, s1);
        check("b2b_1", {24'd0, got}, 32'h61);
        capture(got, s2);
        check("b2b_2", {24'd0, got}, 32'h03);
        check("fsync_gap_a", s1 - s0, FL);
        check("fsync_gap_b", s2 - s1, FL);
        check("underrun_1", {24'd0, under}, 32'd1);
        capture(got, s3);
        check("idle_code", {24'd0, got}, 32'h55);
        check("fsync_gap_c", s3 - s2, FL);
        en = 1'b0;
        repeat (FL) cycle();

        // Back-pressure with EN low, then drain.
        push_burst(8'h01, 8'h01, 5);
        repeat (6) cycle();
        check("bp_level", {29'd0, level}, 32'd4);
        check("bp_ready", {31'd0, ready}, 32'd0);
        en = 1'b1;
        capture(got, s0);
        check("bp_f0", {24'd0, got}, 32'h54);
        check("bp_fifth_accepted", burst, 0);
        capture(got, s0);
        check("bp_f1", {24'd0, got}, 32'h57);
        capture(got, s0);
        check("bp_f2", {24'd0, got}, 32'h56);
        capture(got, s0);
        check("bp_f3", {24'd0, got}, 32'h51);
        capture(got, s0);
        check("bp_f4", {24'd0, got}, 32'h50);
        en = 1'b0;
        repeat (FL) cycle();

        // EN dropped at bit 3 with codes queued.
        push_burst(8'h10, 8'h01, 3);
        repeat (4) cycle();
        en = 1'b1;
        fs = 0;
        while (fsync !== 1'b1 && fs < 4 * FL) begin
            cycle();
            fs++;
        end
        repeat (3 * BIT_DIV) cycle();
        en = 1'b0;
        repeat (FL) cycle();
        check("endrop_level", {29'd0, level}, 32'd2);
        check("endrop_idle", {30'd0, fsync, bclk}, 32'd0);

        // Reset mid-frame.
        en = 1'b1;
        repeat (10) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_async", {17'd0, ready, data, fsync, bclk, level, under}, 32'd0);
        repeat (2) cycle();
        #2;
        rst_n = 1'b1;
        fs = 0;
        repeat (2 * FL) begin
            cycle();
            if (fsync === 1'b1) fs++;
        end
        check("no_frame_after_rst", fs, 0);

        // Random traffic against the model.
        repeat (800) begin
            en = ($urandom % 8) != 0;
            valid = ($urandom % 3) == 0;
            code = 8'($urandom);
            cycle();
        end
        valid = 1'b0;
        en = 1'b0;
        repeat (2 * FL) cycle();

        // Underrun saturation.
        en = 1'b1;
        push_burst(8'h77, 8'h00, 1);
        repeat (301 * FL + 4) cycle();
        check("under_sat", {24'd0, under}, 32'd255);
        capture(got, s0);
        check("sat_line", {24'd0, got}, 32'h55);
        check("under_sat_hold", {24'd0, under}, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
